// File: rtl/ace_pkg.sv
// Shared types and ACE encodings for the cache-side ACE master port.
package ace_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArSend,
    StRRecv,
    StAwSend,
    StWSend,
    StBWait,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    TxnRead,
    TxnWrite,
    TxnInval
  } txn_e;

  localparam logic [3:0] ARSNOOP_READSHARED  = 4'b0001;
  localparam logic [3:0] ARSNOOP_CLEANUNIQUE = 4'b1011;
  localparam logic [2:0] AWSNOOP_WRITEBACK   = 3'b011;
  localparam logic [1:0] RESP_OKAY           = 2'b00;

  // AxLEN encoding of a burst of the given number of beats.
  function automatic logic [7:0] burst_len(input int unsigned beats);
    return 8'(beats - 1);
  endfunction

endpackage

// File: rtl/ace_line_buffer.sv
// One cache line of storage: bulk load for evictions, per-beat write for fills,
// and a word read mux for W beats. All accesses share one beat index.
module ace_line_buffer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_load,
  input  logic [LINE_WORDS*DATA_WIDTH-1:0] i_load_line,
  input  logic                             i_wr_en,
  input  logic [$clog2(LINE_WORDS)-1:0]    i_idx,
  input  logic [DATA_WIDTH-1:0]            i_wr_word,
  output logic [DATA_WIDTH-1:0]            o_rd_word,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] o_line
);

  logic [DATA_WIDTH-1:0] r_mem [LINE_WORDS];

  // Line storage: a whole-line load takes precedence over a single-beat write.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < int'(LINE_WORDS); i++) r_mem[i] <= '0;
    end else if (i_load) begin
      for (int i = 0; i < int'(LINE_WORDS); i++) begin
        r_mem[i] <= i_load_line[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end else if (i_wr_en) begin
      r_mem[i_idx] <= i_wr_word;
    end
  end

  assign o_rd_word = r_mem[i_idx];

  for (genvar g = 0; g < int'(LINE_WORDS); g++) begin : g_line
    assign o_line[g*DATA_WIDTH +: DATA_WIDTH] = r_mem[g];
  end

endmodule

// File: rtl/ace_master_port.sv
// Turns cache-controller request pulses into ReadShared / WriteBack /
// CleanUnique ACE transactions and pulses ace_ready on completion.
module ace_master_port
  import ace_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             read_req,
  input  logic                             write_req,
  input  logic                             invalid_req,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [LINE_WORDS*DATA_WIDTH-1:0] wb_line_data,
  output logic                             ace_ready,
  output logic                             ace_busy,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] fill_line_data,
  output logic                             fill_shared,
  output logic                             resp_err,
  output logic [ADDR_WIDTH-1:0]            araddr,
  output logic                             arvalid,
  input  logic                             arready,
  output logic [3:0]                       arsnoop,
  output logic [7:0]                       arlen,
  input  logic [DATA_WIDTH-1:0]            rdata,
  input  logic [3:0]                       rresp,
  input  logic                             rlast,
  input  logic                             rvalid,
  output logic                             rready,
  output logic [ADDR_WIDTH-1:0]            awaddr,
  output logic                             awvalid,
  input  logic                             awready,
  output logic [2:0]                       awsnoop,
  output logic [7:0]                       awlen,
  output logic [DATA_WIDTH-1:0]            wdata,
  output logic                             wlast,
  output logic                             wvalid,
  input  logic                             wready,
  input  logic [1:0]                       bresp,
  input  logic                             bvalid,
  output logic                             bready,
  output logic                             rack,
  output logic                             wack
);

  localparam int unsigned CntW = $clog2(LINE_WORDS);
  localparam int unsigned OffW = $clog2(LINE_WORDS * DATA_WIDTH / 8);
  localparam logic [CntW-1:0] LastCnt = CntW'(LINE_WORDS - 1);
  localparam logic [7:0] BurstLen = burst_len(LINE_WORDS);

  state_e                r_state;
  txn_e                  r_txn;
  logic [CntW-1:0]       r_cnt;
  logic [ADDR_WIDTH-1:0] r_araddr, r_awaddr;
  logic [3:0]            r_arsnoop;
  logic [2:0]            r_awsnoop;
  logic [7:0]            r_arlen, r_awlen;
  logic                  r_arvalid, r_rready, r_awvalid, r_wvalid, r_bready;
  logic                  r_ace_ready, r_rack, r_wack, r_busy, r_resp_err, r_fill_shared;

  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] w_line_addr;
  logic                  w_buf_load, w_buf_wr;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic                  w_unused;

  assign w_accept    = (r_state == StIdle) && (read_req || write_req || invalid_req);
  assign w_line_addr = {req_addr[ADDR_WIDTH-1:OffW], {OffW{1'b0}}};
  // Evicted line enters the buffer only when the write actually wins arbitration.
  assign w_buf_load  = w_accept && write_req && !invalid_req;
  // CleanUnique data is discarded so the last fill stays intact.
  assign w_buf_wr    = r_rready && rvalid && (r_txn == TxnRead);
  assign w_unused    = ^{rresp[2], req_addr[OffW-1:0]};

  ace_line_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .LINE_WORDS(LINE_WORDS)
  ) u_line_buffer (
    .i_clk      (clk),
    .i_rst      (reset),
    .i_load     (w_buf_load),
    .i_load_line(wb_line_data),
    .i_wr_en    (w_buf_wr),
    .i_idx      (r_cnt),
    .i_wr_word  (rdata),
    .o_rd_word  (w_rd_word),
    .o_line     (fill_line_data)
  );

  // Transaction sequencer with registered channel controls and completion pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= StIdle;
      r_txn         <= TxnRead;
      r_cnt         <= '0;
      r_araddr      <= '0;
      r_awaddr      <= '0;
      r_arsnoop     <= '0;
      r_awsnoop     <= '0;
      r_arlen       <= '0;
      r_awlen       <= '0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_bready      <= 1'b0;
      r_ace_ready   <= 1'b0;
      r_rack        <= 1'b0;
      r_wack        <= 1'b0;
      r_busy        <= 1'b0;
      r_resp_err    <= 1'b0;
      r_fill_shared <= 1'b0;
    end else begin
      r_ace_ready <= 1'b0;
      r_rack      <= 1'b0;
      r_wack      <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_busy     <= 1'b1;
            r_resp_err <= 1'b0;
            r_cnt      <= '0;
            if (invalid_req) begin
              r_txn     <= TxnInval;
              r_araddr  <= w_line_addr;
              r_arsnoop <= ARSNOOP_CLEANUNIQUE;
              r_arlen   <= 8'd0;
              r_arvalid <= 1'b1;
              r_state   <= StArSend;
            end else if (write_req) begin
              r_txn     <= TxnWrite;
              r_awaddr  <= w_line_addr;
              r_awsnoop <= AWSNOOP_WRITEBACK;
              r_awlen   <= BurstLen;
              r_awvalid <= 1'b1;
              r_state   <= StAwSend;
            end else begin
              r_txn     <= TxnRead;
              r_araddr  <= w_line_addr;
              r_arsnoop <= ARSNOOP_READSHARED;
              r_arlen   <= BurstLen;
              r_arvalid <= 1'b1;
              r_state   <= StArSend;
            end
          end
        end
        StArSend: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= StRRecv;
          end
        end
        StRRecv: begin
          if (rvalid) begin
            if (rresp[1:0] != RESP_OKAY) r_resp_err <= 1'b1;
            if (rlast) begin
              r_rready    <= 1'b0;
              r_ace_ready <= 1'b1;
              r_rack      <= 1'b1;
              r_state     <= StDone;
              if (r_txn == TxnRead) begin
                r_fill_shared <= rresp[3];
                // Short burst still completes, but the line is incomplete.
                if (r_cnt != LastCnt) r_resp_err <= 1'b1;
              end
            end else if ((r_txn == TxnRead) && (r_cnt != LastCnt)) begin
              r_cnt <= r_cnt + CntW'(1);
            end
          end
        end
        StAwSend: begin
          if (awready) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b1;
            r_state   <= StWSend;
          end
        end
        StWSend: begin
          if (wready) begin
            if (r_cnt == LastCnt) begin
              r_wvalid <= 1'b0;
              r_bready <= 1'b1;
              r_state  <= StBWait;
            end else begin
              r_cnt <= r_cnt + CntW'(1);
            end
          end
        end
        StBWait: begin
          if (bvalid) begin
            if (bresp != RESP_OKAY) r_resp_err <= 1'b1;
            r_bready    <= 1'b0;
            r_ace_ready <= 1'b1;
            r_wack      <= 1'b1;
            r_state     <= StDone;
          end
        end
        StDone: begin
          r_cnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign ace_ready   = r_ace_ready;
  assign ace_busy    = r_busy;
  assign fill_shared = r_fill_shared;
  assign resp_err    = r_resp_err;
  assign araddr      = r_araddr;
  assign arvalid     = r_arvalid;
  assign arsnoop     = r_arsnoop;
  assign arlen       = r_arlen;
  assign rready      = r_rready;
  assign awaddr      = r_awaddr;
  assign awvalid     = r_awvalid;
  assign awsnoop     = r_awsnoop;
  assign awlen       = r_awlen;
  // Gate the mux so W payload reads as zero whenever no beat is offered.
  assign wdata       = r_wvalid ? w_rd_word : '0;
  assign wlast       = r_wvalid && (r_cnt == LastCnt);
  assign wvalid      = r_wvalid;
  assign bready      = r_bready;
  assign rack        = r_rack;
  assign wack        = r_wack;

endmodule

// File: tb/tb_ace_master_port.sv
// Scoreboard bench for ace_master_port: a small ACE slave responds on all
// channels while a negedge monitor pops expected AR/AW/W/completion records.
module tb_ace_master_port;

  logic         clk, reset;
  logic         read_req, write_req, invalid_req;
  logic [31:0]  req_addr;
  logic [127:0] wb_line_data;
  logic         ace_ready, ace_busy, fill_shared, resp_err;
  logic [127:0] fill_line_data;
  logic [31:0]  araddr, awaddr, rdata, wdata;
  logic         arvalid, arready, rlast, rvalid, rready;
  logic [3:0]   arsnoop, rresp;
  logic [7:0]   arlen, awlen;
  logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready, rack, wack;
  logic [2:0]   awsnoop;
  logic [1:0]   bresp;

  ace_master_port dut (
    .clk(clk), .reset(reset), .read_req(read_req), .write_req(write_req),
    .invalid_req(invalid_req), .req_addr(req_addr), .wb_line_data(wb_line_data),
    .ace_ready(ace_ready), .ace_busy(ace_busy), .fill_line_data(fill_line_data),
    .fill_shared(fill_shared), .resp_err(resp_err), .araddr(araddr), .arvalid(arvalid),
    .arready(arready), .arsnoop(arsnoop), .arlen(arlen), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready), .awaddr(awaddr), .awvalid(awvalid),
    .awready(awready), .awsnoop(awsnoop), .awlen(awlen), .wdata(wdata), .wlast(wlast),
    .wvalid(wvalid), .wready(wready), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .rack(rack), .wack(wack)
  );

  typedef struct packed {logic [31:0] addr; logic [3:0] snoop; logic [7:0] len;} ar_t;
  typedef struct packed {logic [31:0] data; logic last;} w_t;
  typedef struct packed {logic [31:0] data; logic [3:0] resp; logic last;} r_t;
  typedef struct packed {
    logic rack; logic wack; logic err;
    logic chk_fill; logic [127:0] fill;
    logic chk_shared; logic shared;
  } done_t;

  ar_t          exp_ar[$];
  logic [31:0]  exp_aw[$];
  w_t           exp_w[$];
  done_t        exp_done[$];
  r_t           r_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  // ---------------- slave model ----------------
  int   aw_delay = 0;
  int   aw_wait  = 0;
  logic w_toggle = 1'b0;
  logic s_rv, s_rr, s_awv, s_awr, s_wv, s_wr, s_wl, s_bv, s_br;
  r_t   r_pop;

  always @(negedge clk) begin
    s_rv = rvalid; s_rr = rready; s_awv = awvalid; s_awr = awready;
    s_wv = wvalid; s_wr = wready; s_wl = wlast; s_bv = bvalid; s_br = bready;
  end

  always @(posedge clk) begin
    #1;
    if (reset) begin
      r_q.delete();
      rvalid = 1'b0; rlast = 1'b0; rdata = '0; rresp = '0;
      awready = 1'b0; aw_wait = 0; wready = 1'b1; bvalid = 1'b0; bresp = '0;
    end else begin
      if (s_rv && s_rr) r_pop = r_q.pop_front();
      if (r_q.size() > 0) begin
        rvalid = 1'b1; rdata = r_q[0].data; rresp = r_q[0].resp; rlast = r_q[0].last;
      end else begin
        rvalid = 1'b0; rlast = 1'b0;
      end
      if (s_awv && s_awr) begin
        awready = 1'b0; aw_wait = 0;
      end else if (awvalid && !awready) begin
        if (aw_wait >= aw_delay) awready = 1'b1;
        else aw_wait++;
      end
      wready = w_toggle ? ~wready : 1'b1;
      if (s_bv && s_br) bvalid = 1'b0;
      if (s_wv && s_wr && s_wl) begin
        bvalid = 1'b1; bresp = 2'b00;
      end
    end
  end

  // ---------------- monitor ----------------
  ar_t         m_ar;
  logic [31:0] m_aw;
  w_t          m_w;
  done_t       m_d;
  logic        aw_seen = 1'b0;
  logic        b_chk   = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (b_chk) begin
        check_val("wack_after_b", {ace_ready, wack}, 2'b11);
        b_chk = 1'b0;
      end
      if (bvalid && bready) b_chk = 1'b1;
      if (arvalid && arready) begin
        if (exp_ar.size() == 0) check_val("ar_unexpected", arvalid, 1'b0);
        else begin
          m_ar = exp_ar.pop_front();
          check_val("araddr", araddr, m_ar.addr);
          check_val("arsnoop", arsnoop, m_ar.snoop);
          check_val("arlen", arlen, m_ar.len);
        end
      end
      if (awvalid && awready) begin
        aw_seen = 1'b1;
        if (exp_aw.size() == 0) check_val("aw_unexpected", awvalid, 1'b0);
        else begin
          m_aw = exp_aw.pop_front();
          check_val("awaddr", awaddr, m_aw);
          check_val("awsnoop", awsnoop, 3'b011);
          check_val("awlen", awlen, 8'd3);
        end
      end
      if (wvalid) check_val("w_after_aw", aw_seen, 1'b1);
      if (wvalid && wready) begin
        if (exp_w.size() == 0) check_val("w_unexpected", wvalid, 1'b0);
        else begin
          m_w = exp_w.pop_front();
          check_val("wdata", wdata, m_w.data);
          check_val("wlast", wlast, m_w.last);
        end
      end
      if (ace_ready) begin
        aw_seen = 1'b0;
        if (exp_done.size() == 0) check_val("done_unexpected", ace_ready, 1'b0);
        else begin
          m_d = exp_done.pop_front();
          check_val("rack", rack, m_d.rack);
          check_val("wack", wack, m_d.wack);
          check_val("resp_err", resp_err, m_d.err);
          if (m_d.chk_fill) check_val("fill_line", fill_line_data, m_d.fill);
          if (m_d.chk_shared) check_val("fill_shared", fill_shared, m_d.shared);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [127:0] mk_line(input logic [31:0] base);
    return {base + 32'd3, base + 32'd2, base + 32'd1, base};
  endfunction

  task automatic push_fill(input logic [31:0] base, input logic [3:0] resp2,
                           input logic [3:0] resp3);
    r_q.push_back('{data: base,         resp: 4'd0,  last: 1'b0});
    r_q.push_back('{data: base + 32'd1, resp: 4'd0,  last: 1'b0});
    r_q.push_back('{data: base + 32'd2, resp: resp2, last: 1'b0});
    r_q.push_back('{data: base + 32'd3, resp: resp3, last: 1'b1});
  endtask

  task automatic push_wr(input logic [31:0] base);
    for (int i = 0; i < 4; i++) exp_w.push_back('{data: base + 32'(i), last: (i == 3)});
  endtask

  task automatic pulse(input logic rd, input logic wr, input logic inv,
                       input logic [31:0] addr, input logic [127:0] line);
    @(posedge clk); #1;
    read_req = rd; write_req = wr; invalid_req = inv; req_addr = addr; wb_line_data = line;
    @(posedge clk); #1;
    read_req = 1'b0; write_req = 1'b0; invalid_req = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 1;
    forever begin
      @(negedge clk);
      if (ace_ready) break;
      if (n > 60) begin
        check_val("ready_timeout", ace_ready, 1'b1);
        break;
      end
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_val({pfx, "_valids"}, {arvalid, awvalid, wvalid, rready, bready}, 5'b0);
    check_val({pfx, "_pulses"}, {ace_ready, rack, wack, ace_busy}, 4'b0);
    check_val({pfx, "_flags"}, {resp_err, fill_shared, wlast}, 3'b0);
    check_val({pfx, "_addrs"}, {araddr, awaddr}, 64'd0);
    check_val({pfx, "_ctl"}, {arsnoop, awsnoop, arlen, awlen}, 23'd0);
    check_val({pfx, "_wdata"}, wdata, 32'd0);
    check_val({pfx, "_fill"}, fill_line_data, 128'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    reset = 1'b1;
    read_req = 1'b0; write_req = 1'b0; invalid_req = 1'b0;
    req_addr = '0; wb_line_data = '0;
    arready = 1'b1; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0;
    awready = 1'b0; wready = 1'b1; bvalid = 1'b0; bresp = '0;
    #23;
    check_reset_outputs("rst0");
    @(posedge clk); #1;
    reset = 1'b0;

    // Read fill with every ready high: 6-cycle latency.
    exp_ar.push_back('{addr: 32'h1230, snoop: 4'b0001, len: 8'd3});
    push_fill(32'hA0, 4'd0, 4'd0);
    exp_done.push_back('{rack: 1, wack: 0, err: 0, chk_fill: 1, fill: mk_line(32'hA0),
                         chk_shared: 1, shared: 0});
    pulse(1'b1, 1'b0, 1'b0, 32'h1234, '0);
    wait_ready(n);
    check_val("rd_latency", n, 6);
    check_val("busy_in_done", ace_busy, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("busy_after_done", {ace_busy, ace_ready}, 2'b00);

    // Invalidate leaves the fill line untouched.
    exp_ar.push_back('{addr: 32'h40, snoop: 4'b1011, len: 8'd0});
    r_q.push_back('{data: 32'hDEADBEEF, resp: 4'd0, last: 1'b1});
    exp_done.push_back('{rack: 1, wack: 0, err: 0, chk_fill: 1, fill: mk_line(32'hA0),
                         chk_shared: 0, shared: 0});
    pulse(1'b0, 1'b0, 1'b1, 32'h40, '0);
    wait_ready(n);

    // Writeback with delayed AW and toggling W ready.
    aw_delay = 3; w_toggle = 1'b1;
    exp_aw.push_back(32'h2000);
    push_wr(32'hB0);
    exp_done.push_back('{rack: 0, wack: 1, err: 0, chk_fill: 0, fill: '0,
                         chk_shared: 0, shared: 0});
    pulse(1'b0, 1'b1, 1'b0, 32'h2008, mk_line(32'hB0));
    wait_ready(n);
    aw_delay = 0; w_toggle = 1'b0;
    check_val("w_beats_left", exp_w.size(), 0);

    // Simultaneous read+invalidate, then a read pulse while busy.
    exp_ar.push_back('{addr: 32'h80, snoop: 4'b1011, len: 8'd0});
    r_q.push_back('{data: 32'h12345678, resp: 4'd0, last: 1'b1});
    exp_done.push_back('{rack: 1, wack: 0, err: 0, chk_fill: 0, fill: '0,
                         chk_shared: 0, shared: 0});
    pulse(1'b1, 1'b0, 1'b1, 32'h84, '0);
    check_val("busy_on_2nd", ace_busy, 1'b1);
    read_req = 1'b1; req_addr = 32'h300;
    @(posedge clk); #1;
    read_req = 1'b0;
    wait_ready(n);
    repeat (5) @(posedge clk);
    #1;
    check_val("no_extra_ar", {arvalid, 8'(exp_ar.size())}, 9'd0);
    check_val("idle_after_ignored", ace_busy, 1'b0);

    // Error beat and shared response on the last beat.
    exp_ar.push_back('{addr: 32'h100, snoop: 4'b0001, len: 8'd3});
    push_fill(32'hC0, 4'b0010, 4'b1000);
    exp_done.push_back('{rack: 1, wack: 0, err: 1, chk_fill: 1, fill: mk_line(32'hC0),
                         chk_shared: 1, shared: 1});
    pulse(1'b1, 1'b0, 1'b0, 32'h104, '0);
    wait_ready(n);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("err_sticky", {resp_err, ace_ready}, 2'b10);
    exp_ar.push_back('{addr: 32'h140, snoop: 4'b1011, len: 8'd0});
    r_q.push_back('{data: 32'h0, resp: 4'd0, last: 1'b1});
    exp_done.push_back('{rack: 1, wack: 0, err: 0, chk_fill: 1, fill: mk_line(32'hC0),
                         chk_shared: 1, shared: 1});
    pulse(1'b0, 1'b0, 1'b1, 32'h140, '0);
    @(negedge clk);
    check_val("err_cleared", {resp_err, ace_busy}, 2'b01);
    wait_ready(n);

    // Reset during W beat 1 abandons the write.
    exp_aw.push_back(32'h200);
    push_wr(32'hD0);
    exp_done.push_back('{rack: 0, wack: 1, err: 0, chk_fill: 0, fill: '0,
                         chk_shared: 0, shared: 0});
    pulse(1'b0, 1'b1, 1'b0, 32'h200, mk_line(32'hD0));
    n = 0;
    forever begin
      @(negedge clk);
      if (wvalid) break;
      n++;
      if (n > 20) begin
        check_val("wvalid_timeout", wvalid, 1'b1);
        break;
      end
    end
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    exp_aw.delete(); exp_w.delete(); exp_done.delete(); exp_ar.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("no_ready_after_rst", {ace_busy, 8'(exp_done.size())}, 9'd0);

    // A fresh read completes normally after the abort.
    exp_ar.push_back('{addr: 32'h3000, snoop: 4'b0001, len: 8'd3});
    push_fill(32'hE0, 4'd0, 4'd0);
    exp_done.push_back('{rack: 1, wack: 0, err: 0, chk_fill: 1, fill: mk_line(32'hE0),
                         chk_shared: 1, shared: 0});
    pulse(1'b1, 1'b0, 1'b0, 32'h300C, '0);
    wait_ready(n);
    check_val("post_rst_latency", n, 6);
    repeat (2) @(posedge clk);
    #1;
    check_val("done_q_empty", exp_done.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
